vector_mac_accumulator: RTL and testbench

- Sequential matrix-vector multiply stage feeding the per-element right-shift (fixed-point rescale) stage.
- Latches an input activation vector, consumes a row-major weight stream one signed weight per cycle, and accumulates one dot product per output neuron with a single MAC.
- Presents the full-precision accumulated vector to the downstream shift stage through a valid/ready handshake.

---
 rtl/vector_mac_accumulator.sv | 131 +++++++++++++
 tb/tb_vector_mac_accumulator.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mac_accumulator.sv
// Single-MAC matrix-vector multiply: latches an activation vector, consumes a
// row-major signed weight stream and hands the full-precision dot products downstream.
module vector_mac_accumulator #(
  parameter int unsigned MAX_NEURONS = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ACC_W       = 36,
  parameter int unsigned CNT_W       = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [CNT_W-1:0]              num_in,
  input  logic [CNT_W-1:0]              num_out,
  input  logic [MAX_NEURONS*DATA_W-1:0] in_vector,
  input  logic                          w_valid,
  output logic                          w_ready,
  input  logic [DATA_W-1:0]             w_data,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_NEURONS*ACC_W-1:0]  out_vector
);

  localparam int unsigned LANE_W = (MAX_NEURONS > 1) ? $clog2(MAX_NEURONS) : 1;
  localparam int unsigned PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_d;

  logic [MAX_NEURONS*DATA_W-1:0] x_q;
  logic [CNT_W-1:0]              n_in_q;
  logic [CNT_W-1:0]              n_out_q;
  logic [CNT_W-1:0]              row_q;
  logic [CNT_W-1:0]              col_q;
  logic signed [ACC_W-1:0]       acc_q;

  logic [CNT_W-1:0]              num_in_clamp;
  logic [CNT_W-1:0]              num_out_clamp;
  logic signed [DATA_W-1:0]      x_sel;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_W-1:0]       acc_sum;
  logic                          beat;
  logic                          last_col;
  logic                          last_row;
  logic                          zero_dim;

  assign num_in_clamp  = (num_in  > CNT_W'(MAX_NEURONS)) ? CNT_W'(MAX_NEURONS) : num_in;
  assign num_out_clamp = (num_out > CNT_W'(MAX_NEURONS)) ? CNT_W'(MAX_NEURONS) : num_out;
  assign zero_dim      = (num_in == '0) || (num_out == '0);

  // MAC datapath: full-precision signed product, sign-extended into the accumulator
  assign x_sel   = $signed(x_q[col_q[LANE_W-1:0]*DATA_W +: DATA_W]);
  assign prod    = x_sel * $signed(w_data);
  assign acc_sum = acc_q + ACC_W'(prod);

  assign beat     = (state == RUN) && w_valid;
  assign last_col = (col_q == n_in_q - CNT_W'(1));
  assign last_row = (row_q == n_out_q - CNT_W'(1));

  // Handshake flags are pure decodes of the state register
  assign w_ready   = (state == RUN);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = zero_dim ? DONE : RUN;
        end
      end
      RUN: begin
        if (beat && last_col && last_row) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, counters, accumulator and result lanes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      n_in_q     <= '0;
      n_out_q    <= '0;
      row_q      <= '0;
      col_q      <= '0;
      acc_q      <= '0;
      out_vector <= '0;
    end else if ((state == IDLE) && start) begin
      x_q        <= in_vector;
      n_in_q     <= num_in_clamp;
      n_out_q    <= num_out_clamp;
      row_q      <= '0;
      col_q      <= '0;
      acc_q      <= '0;
      out_vector <= '0;
    end else if (beat) begin
      if (last_col) begin
        out_vector[row_q[LANE_W-1:0]*ACC_W +: ACC_W] <= acc_sum;
        acc_q <= '0;
        col_q <= '0;
        row_q <= row_q + CNT_W'(1);
      end else begin
        acc_q <= acc_sum;
        col_q <= col_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vector_mac_accumulator.sv
// Directed self-checking bench for vector_mac_accumulator with hand-computed
// dot products, latency counts, stall/backpressure and async-reset scenarios.
module tb_vector_mac_accumulator;

  localparam int unsigned MAX_NEURONS = 16;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned ACC_W       = 36;
  localparam int unsigned CNT_W       = 5;

  logic                          clk;
  logic                          rst_n;
  logic                          start;
  logic [CNT_W-1:0]              num_in;
  logic [CNT_W-1:0]              num_out;
  logic [MAX_NEURONS*DATA_W-1:0] in_vector;
  logic                          w_valid;
  logic                          w_ready;
  logic [DATA_W-1:0]             w_data;
  logic                          busy;
  logic                          out_valid;
  logic                          out_ready;
  logic [MAX_NEURONS*ACC_W-1:0]  out_vector;

  int n_checks;
  int n_fail;
  int x_tb[MAX_NEURONS];
  int w_tb[256];
  int lat;
  int beats;
  bit ok;

  vector_mac_accumulator #(
    .MAX_NEURONS(MAX_NEURONS),
    .DATA_W     (DATA_W),
    .ACC_W      (ACC_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_in    (num_in),
    .num_out   (num_out),
    .in_vector (in_vector),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vector(out_vector)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint lane(input int j);
    lane = longint'($signed(out_vector[j*ACC_W +: ACC_W]));
  endfunction

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tables();
    for (int k = 0; k < int'(MAX_NEURONS); k++) x_tb[k] = 0;
    for (int k = 0; k < 256; k++) w_tb[k] = 0;
  endtask

  task automatic load_x();
    for (int k = 0; k < int'(MAX_NEURONS); k++)
      in_vector[k*DATA_W +: DATA_W] = DATA_W'(x_tb[k]);
  endtask

  // Start a pass and stream weights until out_valid, the beat limit, or a cycle bound.
  // lat counts cycles from the start cycle (cycle 0) to the current cycle.
  task automatic do_pass(input int ni, input int no, input int limit, input bit stall,
                         input bit disturb, output int lat_o, output int beats_o);
    int idx;
    bit tog;
    bit vld;
    bit took;
    idx = 0;
    tog = 1'b0;
    load_x();
    num_in  = CNT_W'(ni);
    num_out = CNT_W'(no);
    start   = 1'b1;
    w_valid = 1'b0;
    tick();
    start = 1'b0;
    lat_o = 1;
    while (!out_valid && lat_o < 2000 && idx < limit) begin
      start = 1'b0;
      if (disturb && lat_o == 3) begin
        start     = 1'b1;
        in_vector = ~in_vector;
        num_in    = CNT_W'(1);
      end
      vld     = !(stall && tog);
      tog     = !tog;
      w_valid = vld;
      w_data  = DATA_W'(w_tb[(idx < 256) ? idx : 0]);
      took    = vld && w_ready;
      tick();
      lat_o++;
      if (took) idx++;
    end
    start   = 1'b0;
    w_valid = 1'b0;
    beats_o = idx;
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_busy_after_ack"}, longint'(busy), 0);
    check({tag, "_valid_after_ack"}, longint'(out_valid), 0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    num_in    = '0;
    num_out   = '0;
    in_vector = '0;
    w_valid   = 1'b0;
    w_data    = '0;
    out_ready = 1'b0;

    #2;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_w_ready", longint'(w_ready), 0);
    check("rst_out_vector_zero", longint'(out_vector == '0), 1);
    #10 rst_n = 1'b1;
    tick();

    // 2x2 identity
    clear_tables();
    x_tb[0] = 3; x_tb[1] = -5;
    w_tb[0] = 1; w_tb[1] = 0; w_tb[2] = 0; w_tb[3] = 1;
    do_pass(2, 2, 1000, 1'b0, 1'b0, lat, beats);
    check("id_out_valid", longint'(out_valid), 1);
    check("id_latency", lat, 5);
    check("id_lane0", lane(0), 3);
    check("id_lane1", lane(1), -5);
    ok = 1'b1;
    for (int j = 2; j < int'(MAX_NEURONS); j++) if (lane(j) != 0) ok = 1'b0;
    check("id_upper_lanes_zero", longint'(ok), 1);
    handshake("id");

    // Full size with most-negative operands
    clear_tables();
    for (int k = 0; k < int'(MAX_NEURONS); k++) x_tb[k] = -32768;
    for (int k = 0; k < 256; k++) w_tb[k] = -32768;
    do_pass(16, 16, 1000, 1'b0, 1'b0, lat, beats);
    check("ext_latency", lat, 257);
    for (int j = 0; j < int'(MAX_NEURONS); j++)
      check($sformatf("ext_lane%0d", j), lane(j), 64'sd17179869184);
    handshake("ext");

    // Stalled weight stream, then backpressure
    clear_tables();
    x_tb[0] = 1; x_tb[1] = 2; x_tb[2] = 3;
    w_tb[0] = 4; w_tb[1] = 5; w_tb[2] = 6;
    do_pass(3, 1, 1000, 1'b1, 1'b0, lat, beats);
    check("stall_latency", lat, 6);
    check("stall_beats", beats, 3);
    check("stall_lane0", lane(0), 32);
    check("stall_lane1", lane(1), 0);
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!out_valid || !busy || lane(0) != 32 || lane(1) != 0) ok = 1'b0;
    end
    check("hold_stable", longint'(ok), 1);
    handshake("hold");

    // Start pulse and input changes during RUN are ignored
    clear_tables();
    x_tb[0] = 2; x_tb[1] = -1; x_tb[2] = 4;
    w_tb[0] = 1;  w_tb[1] = 2; w_tb[2] = 3;
    w_tb[3] = -2; w_tb[4] = 0; w_tb[5] = 5;
    do_pass(3, 2, 1000, 1'b0, 1'b1, lat, beats);
    check("ign_latency", lat, 7);
    check("ign_lane0", lane(0), 12);
    check("ign_lane1", lane(1), 16);
    handshake("ign");
    tick();
    check("ign_no_second_pass", longint'(busy), 0);

    // Zero input dimension
    clear_tables();
    x_tb[0] = 9; x_tb[1] = 9;
    do_pass(0, 4, 1000, 1'b0, 1'b0, lat, beats);
    check("zero_latency", lat, 1);
    check("zero_beats", beats, 0);
    check("zero_w_ready", longint'(w_ready), 0);
    check("zero_out_valid", longint'(out_valid), 1);
    check("zero_vector", longint'(out_vector == '0), 1);
    handshake("zero");

    // Asynchronous reset partway through a 4x4 pass
    clear_tables();
    x_tb[0] = 1; x_tb[1] = 2; x_tb[2] = 3; x_tb[3] = 4;
    for (int k = 0; k < 16; k++) w_tb[k] = 1;
    do_pass(4, 4, 9, 1'b0, 1'b0, lat, beats);
    check("abort_beats", beats, 9);
    check("abort_partial_lane0", lane(0), 10);
    check("abort_partial_lane1", lane(1), 10);
    check("abort_busy_before", longint'(busy), 1);
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", longint'(busy), 0);
    check("abort_w_ready", longint'(w_ready), 0);
    check("abort_out_valid", longint'(out_valid), 0);
    check("abort_vector_zero", longint'(out_vector == '0), 1);
    #2 rst_n = 1'b1;
    tick();

    clear_tables();
    x_tb[0] = 7; x_tb[1] = -2;
    w_tb[0] = 1; w_tb[1] = 1; w_tb[2] = 2; w_tb[3] = -3;
    do_pass(2, 2, 1000, 1'b0, 1'b0, lat, beats);
    check("fresh_latency", lat, 5);
    check("fresh_lane0", lane(0), 5);
    check("fresh_lane1", lane(1), 20);
    check("fresh_lane2", lane(2), 0);
    handshake("fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
